// File: rtl/csel_subtractor_seq.sv
// -----------------------------------------------------------------------------
// csel_subtractor_seq
//
// Multi-cycle carry-select subtractor: diff = a - b - bin (modulo 2^WIDTH),
// one CHUNK-bit slice per clock, LSB slice first. Each slice is subtracted
// twice in parallel (borrow-in 0 and borrow-in 1). The running borrow picks
// which candidate is kept and which borrow propagates to the next slice.
//
// Parameters:
//   WIDTH - operand/result width (must be an integer multiple of CHUNK)
//   CHUNK - slice width processed per cycle; NSLICE = WIDTH/CHUNK cycles/op
//
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (aborts any operation)
//   start in   request, only sampled while idle
//   a     in   minuend, captured on accepted start
//   b     in   subtrahend, captured on accepted start
//   bin   in   borrow-in, captured on accepted start
//   busy  out  high while an operation is running or completing
//   done  out  one-cycle pulse, result valid
//   diff  out  registered difference (holds until the next accepted start)
//   bout  out  registered borrow-out (1 when a < b + bin, unsigned)
//   ovf   out  (only with CSEL_SUB_OVF_EN) signed two's-complement overflow
//
// Optional feature: define CSEL_SUB_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module csel_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSEL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice candidate: CHUNK result bits plus the borrow in the MSB.
  function automatic logic [CHUNK:0] slice_sub(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             bi
  );
    slice_sub = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
  endfunction

  state_t           state_r,  state_n;
  logic [WIDTH-1:0] a_r,      a_n;
  logic [WIDTH-1:0] b_r,      b_n;
  logic [IDXW-1:0]  idx_r,    idx_n;
  logic             borrow_r, borrow_n;
  logic [WIDTH-1:0] diff_r,   diff_n;
  logic             bout_r,   bout_n;
  logic             done_r,   done_n;
  logic             busy_r,   busy_n;
`ifdef CSEL_SUB_OVF_EN
  logic             ovf_r,    ovf_n;
`endif

  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK:0]   d0_s;
  logic [CHUNK:0]   d1_s;
  logic [CHUNK:0]   sel_s;

  // Current slice of the captured operands and both borrow-in candidates.
  always_comb begin
    a_slice_s = a_r[idx_r*CHUNK +: CHUNK];
    b_slice_s = b_r[idx_r*CHUNK +: CHUNK];
    d0_s      = slice_sub(a_slice_s, b_slice_s, 1'b0);
    d1_s      = slice_sub(a_slice_s, b_slice_s, 1'b1);
    if (borrow_r) begin
      sel_s = d1_s;
    end else begin
      sel_s = d0_s;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_n  = state_r;
    a_n      = a_r;
    b_n      = b_r;
    idx_n    = idx_r;
    borrow_n = borrow_r;
    diff_n   = diff_r;
    bout_n   = bout_r;
    done_n   = 1'b0;
    busy_n   = busy_r;
`ifdef CSEL_SUB_OVF_EN
    ovf_n    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          a_n      = a;
          b_n      = b;
          borrow_n = bin;
          idx_n    = {IDXW{1'b0}};
          busy_n   = 1'b1;
          state_n  = RUN;
        end else begin
          busy_n   = 1'b0;
        end
      end
      RUN: begin
        busy_n   = 1'b1;
        // diff is deliberately not cleared on start; slices are overwritten in turn.
        diff_n[idx_r*CHUNK +: CHUNK] = sel_s[CHUNK-1:0];
        borrow_n = sel_s[CHUNK];
        if (idx_r == LAST_IDX) begin
          bout_n  = sel_s[CHUNK];
          done_n  = 1'b1;
          idx_n   = {IDXW{1'b0}};
          state_n = DONE;
`ifdef CSEL_SUB_OVF_EN
          // Signs of operands differ and result sign differs from the minuend.
          ovf_n   = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_n[WIDTH-1] ^ a_r[WIDTH-1]);
`endif
        end else begin
          idx_n   = idx_r + IDXW'(1);
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      idx_r    <= {IDXW{1'b0}};
      borrow_r <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      a_r      <= a_n;
      b_r      <= b_n;
      idx_r    <= idx_n;
      borrow_r <= borrow_n;
      diff_r   <= diff_n;
      bout_r   <= bout_n;
      done_r   <= done_n;
      busy_r   <= busy_n;
`ifdef CSEL_SUB_OVF_EN
      ovf_r    <= ovf_n;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
`ifdef CSEL_SUB_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_csel_subtractor_seq.sv
// -----------------------------------------------------------------------------
// tb_csel_subtractor_seq
//
// Self-checking bench for csel_subtractor_seq (WIDTH=16, CHUNK=4): a table of
// directed vectors with hand-computed results, plus hand-written sequences for
// ignored start, asynchronous reset mid-operation and back-to-back operation.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_csel_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef CSEL_SUB_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  csel_subtractor_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef CSEL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation with a start pulse, scramble the inputs after
  // capture, and wait (bounded) for done. lat = posedges from start edge to done.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output logic [15:0] od, output logic obo, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ia ^ ib; bin = ~ibin;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    od = diff; obo = bout;
  endtask

  initial begin
    logic [15:0] rd;
    logic        rbo;
    int          lat;
    int          bcnt;
    int          ndone;
    int          t;
    int          last_t;
    logic [15:0] bb_a  [3];
    logic [15:0] bb_b  [3];
    logic        bb_bin[3];
    logic [15:0] bb_d  [3];
    logic        bb_bo [3];

    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5]  = '{16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[10] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {16'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
`ifdef CSEL_SUB_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rbo, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd5);
      check($sformatf("vec%0d_diff", i), {16'd0, rd}, {16'd0, vecs[i].d});
      check($sformatf("vec%0d_bout", i), {31'd0, rbo}, {31'd0, vecs[i].bo});
`ifdef CSEL_SUB_OVF_EN
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_hold_diff", i), {16'd0, diff}, {16'd0, vecs[i].d});
    end

    // start while busy is ignored: single done, first operands' result.
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    ndone = 0; rd = 16'h0000;
    for (int k = 0; k < 14; k++) begin
      if (k == 1) start = 1'b0;
      if (done) begin
        ndone++;
        rd = diff;
      end
      @(negedge clk);
    end
    check("ignore_done_count", ndone, 32'd1);
    check("ignore_diff", {16'd0, rd}, 32'h0000_00E1);
    check("ignore_final_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during the second RUN cycle.
    a = 16'h5555; b = 16'h0000; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_diff", {16'd0, diff}, 32'd0);
    check("arst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("arst_no_done", ndone, 32'd0);
    run_op(16'h8000, 16'h7FFF, 1'b0, rd, rbo, lat, bcnt);
    check("arst_after_latency", lat, 32'd4);
    check("arst_after_diff", {16'd0, rd}, 32'h0000_0001);
    check("arst_after_bout", {31'd0, rbo}, 32'd0);

    // Back-to-back with start held high.
    bb_a[0] = 16'h1111; bb_b[0] = 16'h0222; bb_bin[0] = 1'b0; bb_d[0] = 16'h0EEF; bb_bo[0] = 1'b0;
    bb_a[1] = 16'h0100; bb_b[1] = 16'h0200; bb_bin[1] = 1'b0; bb_d[1] = 16'hFF00; bb_bo[1] = 1'b1;
    bb_a[2] = 16'hFFFF; bb_b[2] = 16'h0000; bb_bin[2] = 1'b1; bb_d[2] = 16'hFFFE; bb_bo[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; bin = bb_bin[0]; start = 1'b1;
    @(negedge clk);
    ndone = 0; t = 0; last_t = -1;
    while (ndone < 3 && t < 40) begin
      if (done) begin
        check($sformatf("b2b%0d_diff", ndone), {16'd0, diff}, {16'd0, bb_d[ndone]});
        check($sformatf("b2b%0d_bout", ndone), {31'd0, bout}, {31'd0, bb_bo[ndone]});
        if (last_t < 0) check("b2b_first_latency", t, 32'd4);
        else            check($sformatf("b2b%0d_spacing", ndone), t - last_t, 32'd6);
        last_t = t;
        ndone++;
        if (ndone < 3) begin
          a = bb_a[ndone]; b = bb_b[ndone]; bin = bb_bin[ndone];
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
